// File: rtl/csr_exec.sv
// csr_exec: execute-stage unit for RV32 Zicsr (CSRRW/RS/RC and immediate forms).
// Does an atomic read-modify-write on a small machine CSR set plus the 64-bit
// cycle/instret counters, returns the old value for rd and flags illegal use.
// Ports:
//   clk_i, rst_n_i        clock (rising edge), synchronous active-low reset
//   req_i                 start op, held high by the core until done_o
//   funct3_i, csr_adr_i   instruction fields instr[14:12], instr[31:20]
//   rs1_idx_i, rs1_val_i  rs1 index (zimm for immediate forms) and rs1 value
//   instret_inc_i         one pulse per retired instruction
//   busy_o                op in progress
//   done_o                one-cycle completion pulse
//   illegal_o             valid with done_o: access was illegal
//   rd_val_o              old CSR value, held until the next op reads
module csr_exec #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_adr_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [31:0] rs1_val_i,
  input  logic        instret_inc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        illegal_o,
  output logic [31:0] rd_val_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
  state_e state_q, state_d;

  // latched operation
  logic [1:0]  op_q;
  logic [11:0] adr_q;
  logic [4:0]  idx_q;
  logic [31:0] src_q;

  // architectural state
  logic [63:0] cyc_q, ins_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;

  // results carried from READ to WRITE/DONE
  logic [31:0] rd_q, new_q;
  logic        ill_q, we_q;

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i) state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    illegal_o = (state_q == S_DONE) & ill_q;
  end
  assign rd_val_o = rd_q;

  // CSR read mux and legality, from the latched fields
  logic [31:0] old_v, new_v;
  logic        hit, suppress, ill;

  always_comb begin
    hit   = 1'b1;
    old_v = '0;
    case (adr_q)
      12'hC00, 12'hC01: old_v = cyc_q[31:0];
      12'hC80, 12'hC81: old_v = cyc_q[63:32];
      12'hC02:          old_v = ins_q[31:0];
      12'hC82:          old_v = ins_q[63:32];
      12'h305:          old_v = {mtvec_q[31:2], 2'b00};
      12'h340:          old_v = mscratch_q;
      12'h341:          old_v = {mepc_q[31:2], 2'b00};
      12'h342:          old_v = mcause_q;
      default:          hit   = 1'b0;
    endcase
    // set/clear with rs1=x0 (or zimm=0) is a pure read
    suppress = op_q[1] && (idx_q == 5'd0);
    ill      = !hit || (op_q == 2'b00) || (!suppress && (adr_q[11:10] == 2'b11));
    case (op_q)
      2'b01:   new_v = src_q;
      2'b10:   new_v = old_v | src_q;
      2'b11:   new_v = old_v & ~src_q;
      default: new_v = old_v;
    endcase
  end

  // datapath
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_q       <= '0;
      adr_q      <= '0;
      idx_q      <= '0;
      src_q      <= '0;
      cyc_q      <= '0;
      ins_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      rd_q       <= '0;
      new_q      <= '0;
      ill_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      // counters are read-only, so nothing else ever writes them
      cyc_q <= cyc_q + 64'd1;
      if (instret_inc_i) ins_q <= ins_q + 64'd1;

      if (state_q == S_IDLE && req_i) begin
        op_q  <= funct3_i[1:0];
        adr_q <= csr_adr_i;
        idx_q <= rs1_idx_i;
        src_q <= funct3_i[2] ? {27'b0, rs1_idx_i} : rs1_val_i;
      end

      if (state_q == S_READ) begin
        rd_q  <= ill ? 32'h0 : old_v;
        ill_q <= ill;
        new_q <= new_v;
        we_q  <= !ill && !suppress;
      end

      if (state_q == S_WRITE && we_q) begin
        case (adr_q)
          12'h305: mtvec_q    <= {new_q[31:2], 2'b00};
          12'h340: mscratch_q <= new_q;
          12'h341: mepc_q     <= {new_q[31:2], 2'b00};
          12'h342: mcause_q   <= new_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_exec.sv
module tb_csr_exec;
  localparam logic [31:0] MTV = 32'h8000_0103;

  logic        clk, rst_n, req, instret_inc, inc_force, inc_rnd, rnd_en;
  logic [2:0]  funct3;
  logic [11:0] csr_adr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_val, rd_val;
  logic        busy, done, illegal;

  csr_exec #(.MTVEC_RESET(MTV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .funct3_i(funct3),
    .csr_adr_i(csr_adr), .rs1_idx_i(rs1_idx), .rs1_val_i(rs1_val),
    .instret_inc_i(instret_inc), .busy_o(busy), .done_o(done),
    .illegal_o(illegal), .rd_val_o(rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instret_inc = inc_force | inc_rnd;
  always @(negedge clk) inc_rnd = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // reference model: counters as plain event counts, CSRs as variables
  logic [63:0] cyc_base, cyc_off, ins_m;
  logic [31:0] mtvec_m, mscr_m, mepc_m, mcause_m;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc_base <= '0;
      ins_m    <= '0;
    end else begin
      cyc_base <= cyc_base + 64'd1;
      ins_m    <= ins_m + 64'(instret_inc);
    end
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc_off  = '0;
    mtvec_m  = MTV & ~32'h3;
    mscr_m   = '0;
    mepc_m   = '0;
    mcause_m = '0;
  endtask

  function automatic void ref_rd(input logic [11:0] a, input logic [63:0] c,
                                 input logic [63:0] n, output logic hit,
                                 output logic [31:0] v);
    hit = 1'b1;
    v   = '0;
    case (a)
      12'hC00, 12'hC01: v = c[31:0];
      12'hC80, 12'hC81: v = c[63:32];
      12'hC02:          v = n[31:0];
      12'hC82:          v = n[63:32];
      12'h305:          v = mtvec_m;
      12'h340:          v = mscr_m;
      12'h341:          v = mepc_m;
      12'h342:          v = mcause_m;
      default:          hit = 1'b0;
    endcase
  endfunction

  // one complete op; leaves the bench at the negedge where done is high
  task automatic do_op(input logic [2:0] f3, input logic [11:0] adr,
                       input logic [4:0] idx, input logic [31:0] val);
    logic [63:0] c, n;
    logic [31:0] old, src, nw;
    logic        hit, wr, ill;
    int          lat;
    @(negedge clk);
    funct3 = f3; csr_adr = adr; rs1_idx = idx; rs1_val = val; req = 1'b1;
    @(posedge clk); #1;
    c = cyc_base + cyc_off;
    n = ins_m;
    chk("busy_read", 64'(busy), 64'd1);
    // scramble inputs: the op must use the latched copy
    funct3 = 3'($urandom); csr_adr = 12'($urandom);
    rs1_idx = 5'($urandom); rs1_val = $urandom;
    src = f3[2] ? {27'b0, idx} : val;
    ref_rd(adr, c, n, hit, old);
    wr  = !(f3[1] && idx == 5'd0);
    ill = !hit || (f3[1:0] == 2'b00) || (wr && adr[11:10] == 2'b11);
    nw  = (f3[1:0] == 2'b01) ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 8);
    chk("latency", 64'(lat), 64'd3);
    chk("illegal", 64'(illegal), 64'(ill));
    chk("rd_val", 64'(rd_val), ill ? 64'd0 : 64'(old));
    req = 1'b0;
    if (!ill && wr) begin
      case (adr)
        12'h305: mtvec_m  = nw & ~32'h3;
        12'h340: mscr_m   = nw;
        12'h341: mepc_m   = nw & ~32'h3;
        12'h342: mcause_m = nw;
        default: ;
      endcase
    end
  endtask

  logic [11:0] adr_tab [12] = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                                12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'hF11};

  initial begin
    rst_n = 1'b0; req = 1'b0; funct3 = '0; csr_adr = '0; rs1_idx = '0; rs1_val = '0;
    inc_force = 1'b0; rnd_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_rd_val", 64'(rd_val), 64'd0);
    rst_n = 1'b1;

    // cycle read with x0
    do_op(3'b010, 12'hC00, 5'd0, 32'h0);
    chk("cycle_legal", 64'(illegal), 64'd0);

    // mscratch RW / RS / RCI
    do_op(3'b001, 12'h340, 5'd1, 32'hDEADBEEF);
    do_op(3'b010, 12'h340, 5'd2, 32'h0000_0010);
    chk("mscr_rs_old", 64'(rd_val), 64'hDEADBEEF);
    do_op(3'b111, 12'h340, 5'h0F, 32'h0);
    chk("mscr_rci_old", 64'(rd_val), 64'hDEADBEFF);
    do_op(3'b010, 12'h340, 5'd0, 32'h0);
    chk("mscr_after_rci", 64'(rd_val), 64'hDEADBEF0);

    // mepc alignment, mtvec reset value
    do_op(3'b001, 12'h341, 5'd3, 32'h0000_1003);
    do_op(3'b010, 12'h341, 5'd0, 32'h0);
    chk("mepc_align", 64'(rd_val), 64'h0000_1000);
    do_op(3'b010, 12'h305, 5'd0, 32'h0);
    chk("mtvec_reset", 64'(rd_val), 64'(MTV & ~32'h3));

    // illegal accesses
    do_op(3'b001, 12'hC00, 5'd1, 32'h1);
    chk("ill_cycle_wr", 64'(illegal), 64'd1);
    do_op(3'b010, 12'h7C0, 5'd0, 32'h0);
    chk("ill_adr", 64'(illegal), 64'd1);
    do_op(3'b100, 12'h340, 5'd1, 32'h5);
    chk("ill_f3", 64'(illegal), 64'd1);
    do_op(3'b010, 12'h340, 5'd0, 32'h0);
    chk("mscr_untouched", 64'(rd_val), 64'hDEADBEF0);

    // instret: seven pulses
    repeat (7) begin @(negedge clk); inc_force = 1'b1; end
    @(negedge clk); inc_force = 1'b0;
    do_op(3'b010, 12'hC02, 5'd0, 32'h0);
    chk("instret7", 64'(rd_val), 64'd7);

    // cycle low-word wrap with carry into the upper word
    @(negedge clk);
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    release dut.cyc_q;
    cyc_off = 64'h0000_0000_FFFF_FFFE - cyc_base;
    do_op(3'b010, 12'hC80, 5'd0, 32'h0);
    chk("cycleh_carry", 64'(rd_val), 64'd1);
    do_op(3'b010, 12'hC01, 5'd0, 32'h0);

    // reset during WRITE aborts the op
    @(negedge clk);
    funct3 = 3'b001; csr_adr = 12'h340; rs1_idx = 5'd1; rs1_val = 32'h1; req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    model_reset();
    do_op(3'b010, 12'h340, 5'd0, 32'h0);
    chk("abort_mscr", 64'(rd_val), 64'd0);

    // randomized ops against the model
    rnd_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      logic [4:0] idx;
      f3  = 3'($urandom);
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op(f3, adr_tab[$urandom_range(0, 11)], idx, $urandom);
    end
    rnd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
